// File: rtl/seq_alu.sv
// seq_alu: sequential ALU with single-cycle integer ops and an optional iterative mul/div engine.
// Define SEQ_ALU_MULDIV_EN to build the shift-add multiplier and restoring divider.
module seq_alu #(
  parameter int XLEN = 32,
  parameter int SHW  = $clog2(XLEN)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [4:0]      op,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  input  logic            flush,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] result,
  output logic            busy
);

  typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} state_t;
  state_t state;

  // Single-cycle integer ops; op[4]=1 and undefined codes yield zero.
  function automatic logic [XLEN-1:0] alu_base(input logic [4:0]      f_op,
                                               input logic [XLEN-1:0] f_a,
                                               input logic [XLEN-1:0] f_b);
    logic signed [XLEN-1:0] sa;
    logic signed [XLEN-1:0] sb;
    logic [SHW-1:0]         sh;
    logic [XLEN-1:0]        r;
    sa = f_a;
    sb = f_b;
    sh = f_b[SHW-1:0];
    r  = '0;
    if (!f_op[4]) begin
      case (f_op[3:0])
        4'b0000: r = f_a + f_b;
        4'b0001: r = f_a - f_b;
        4'b0100: r = f_a & f_b;
        4'b0101: r = f_a | f_b;
        4'b0110: r = f_a ^ f_b;
        4'b1000: r[0] = (sa < sb);
        4'b1001: r[0] = (f_a < f_b);
        4'b1100: r = f_a << sh;
        4'b1101: r = f_a >> sh;
        4'b1110: r = sa >>> sh;
        default: r = '0;
      endcase
    end
    return r;
  endfunction

`ifdef SEQ_ALU_MULDIV_EN
  localparam logic [XLEN-1:0] MOST_NEG = {1'b1, {(XLEN-1){1'b0}}};

  logic [XLEN-1:0]   hi_acc;
  logic [XLEN-1:0]   lo_acc;
  logic [XLEN-1:0]   opnd;
  logic              neg_main;
  logic              neg_rem;
  logic [1:0]        fn;
  logic [SHW-1:0]    cnt;

  logic [XLEN:0]     mul_sum;
  logic [XLEN:0]     div_shift;
  logic              div_bit;
  logic [XLEN-1:0]   mul_hi_nx;
  logic [XLEN-1:0]   mul_lo_nx;
  logic [XLEN-1:0]   div_hi_nx;
  logic [XLEN-1:0]   div_lo_nx;
  logic [2*XLEN-1:0] prod;
  logic [XLEN-1:0]   mul_res;
  logic [XLEN-1:0]   div_res;
  logic [XLEN-1:0]   quo;
  logic [XLEN-1:0]   rem;

  function automatic logic [XLEN-1:0] mag(input logic [XLEN-1:0] v, input logic sgn);
    return (sgn && v[XLEN-1]) ? -v : v;
  endfunction

  // Divide-by-zero and signed overflow resolve immediately instead of iterating.
  function automatic logic is_special(input logic [2:0]      f,
                                      input logic [XLEN-1:0] f_a,
                                      input logic [XLEN-1:0] f_b);
    return f[2] && ((f_b == '0) || (!f[0] && f_a == MOST_NEG && f_b == '1));
  endfunction

  function automatic logic [XLEN-1:0] special_res(input logic [2:0]      f,
                                                  input logic [XLEN-1:0] f_a,
                                                  input logic [XLEN-1:0] f_b);
    if (f_b == '0) return f[1] ? f_a : '1;
    return f[1] ? '0 : f_a;
  endfunction

  // Operands are held as magnitudes; the sign is reapplied on the final step.
  always_comb begin
    mul_sum   = {1'b0, hi_acc} + (lo_acc[0] ? {1'b0, opnd} : '0);
    mul_hi_nx = mul_sum[XLEN:1];
    mul_lo_nx = {mul_sum[0], lo_acc[XLEN-1:1]};
    prod      = {mul_hi_nx, mul_lo_nx};
    if (neg_main) prod = -prod;
    mul_res   = (fn == 2'b00) ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN];

    div_shift = {hi_acc, lo_acc[XLEN-1]};
    div_bit   = (div_shift >= {1'b0, opnd});
    div_hi_nx = div_bit ? XLEN'(div_shift - {1'b0, opnd}) : div_shift[XLEN-1:0];
    div_lo_nx = {lo_acc[XLEN-2:0], div_bit};
    quo       = neg_main ? -div_lo_nx : div_lo_nx;
    rem       = neg_rem ? -div_hi_nx : div_hi_nx;
    div_res   = fn[1] ? rem : quo;
  end
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      result    <= '0;
      out_valid <= 1'b0;
      in_ready  <= 1'b1;
      busy      <= 1'b0;
`ifdef SEQ_ALU_MULDIV_EN
      hi_acc    <= '0;
      lo_acc    <= '0;
      opnd      <= '0;
      neg_main  <= 1'b0;
      neg_rem   <= 1'b0;
      fn        <= '0;
      cnt       <= '0;
`endif
    end else if (flush) begin
      state     <= IDLE;
      out_valid <= 1'b0;
      in_ready  <= 1'b1;
      busy      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid && in_ready) begin
            in_ready <= 1'b0;
`ifdef SEQ_ALU_MULDIV_EN
            if (op[4] && !is_special(op[2:0], a, b)) begin
              fn     <= op[1:0];
              cnt    <= '0;
              busy   <= 1'b1;
              hi_acc <= '0;
              if (op[2]) begin
                state    <= DIV;
                lo_acc   <= mag(a, !op[0]);
                opnd     <= mag(b, !op[0]);
                neg_main <= !op[0] && (a[XLEN-1] ^ b[XLEN-1]);
                neg_rem  <= !op[0] && a[XLEN-1];
              end else begin
                // mulh: both signed; mulhsu: only a signed; mul/mulhu: unsigned
                state    <= MUL;
                lo_acc   <= mag(a, op[1:0] == 2'b01 || op[1:0] == 2'b10);
                opnd     <= mag(b, op[1:0] == 2'b01);
                neg_main <= ((op[1:0] == 2'b01 || op[1:0] == 2'b10) && a[XLEN-1]) ^
                            ((op[1:0] == 2'b01) && b[XLEN-1]);
                neg_rem  <= 1'b0;
              end
            end else begin
              state     <= DONE;
              out_valid <= 1'b1;
              result    <= op[4] ? special_res(op[2:0], a, b) : alu_base(op, a, b);
            end
`else
            state     <= DONE;
            out_valid <= 1'b1;
            result    <= alu_base(op, a, b);
`endif
          end
        end
`ifdef SEQ_ALU_MULDIV_EN
        MUL: begin
          hi_acc <= mul_hi_nx;
          lo_acc <= mul_lo_nx;
          cnt    <= cnt + 1'b1;
          if (cnt == SHW'(XLEN-1)) begin
            state     <= DONE;
            result    <= mul_res;
            out_valid <= 1'b1;
            busy      <= 1'b0;
          end
        end
        DIV: begin
          hi_acc <= div_hi_nx;
          lo_acc <= div_lo_nx;
          cnt    <= cnt + 1'b1;
          if (cnt == SHW'(XLEN-1)) begin
            state     <= DONE;
            result    <= div_res;
            out_valid <= 1'b1;
            busy      <= 1'b0;
          end
        end
`endif
        DONE: begin
          if (out_ready) begin
            state     <= IDLE;
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
          end
        end
        default: begin
          state     <= IDLE;
          out_valid <= 1'b0;
          in_ready  <= 1'b1;
          busy      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_seq_alu.sv
// Directed bench for seq_alu at XLEN=32 and XLEN=8; expectations follow SEQ_ALU_MULDIV_EN.
module tb_seq_alu;
`ifdef SEQ_ALU_MULDIV_EN
  localparam bit MD = 1'b1;
`else
  localparam bit MD = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid, in_ready, flush, out_valid, out_ready, busy;
  logic [4:0]  op;
  logic [31:0] a, b, result;
  logic        e_in_valid, e_in_ready, e_flush, e_out_valid, e_out_ready, e_busy;
  logic [4:0]  e_op;
  logic [7:0]  e_a, e_b, e_result;
  int          n_cmp = 0;
  int          n_fail = 0;

  seq_alu #(.XLEN(32)) u_alu32 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .op(op),
    .a(a), .b(b), .flush(flush), .out_valid(out_valid), .out_ready(out_ready),
    .result(result), .busy(busy)
  );

  seq_alu #(.XLEN(8)) u_alu8 (
    .clk(clk), .rst_n(rst_n), .in_valid(e_in_valid), .in_ready(e_in_ready), .op(e_op),
    .a(e_a), .b(e_b), .flush(e_flush), .out_valid(e_out_valid), .out_ready(e_out_ready),
    .result(e_result), .busy(e_busy)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [4:0] o, input logic [31:0] x, input logic [31:0] y);
    op = o; a = x; b = y; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
  endtask

  task automatic consume();
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
  endtask

  // Latency counts the accept edge as cycle 1; -1 marks an expired wait.
  task automatic wait_done(output int lat, output int bcnt);
    lat = 1; bcnt = 0;
    while (!out_valid && lat < 200) begin
      if (busy) bcnt++;
      tick();
      lat++;
    end
    if (!out_valid) lat = -1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; in_valid = 1'b0; flush = 1'b0; out_ready = 1'b0;
    op = '0; a = '0; b = '0;
    e_in_valid = 1'b0; e_flush = 1'b0; e_out_ready = 1'b0;
    e_op = '0; e_a = '0; e_b = '0;
    repeat (3) tick();
    n_cmp++; if (result !== 32'h0) begin n_fail++; $display("FAIL reset_result: got %h want 0", result); end
    n_cmp++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
    n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", busy); end
    n_cmp++; if ({e_out_valid, e_result} !== 9'h0) begin n_fail++; $display("FAIL reset_x8: got %b/%h want 0/00", e_out_valid, e_result); end
    rst_n = 1'b1;
    tick();
    n_cmp++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
    n_cmp++; if (e_in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready_x8: got %b want 1", e_in_ready); end
  endtask

  task automatic test_single();
    logic [4:0]  t_op [12];
    logic [31:0] t_a [12];
    logic [31:0] t_b [12];
    logic [31:0] t_r [12];
    int lat, bc;
    t_op = '{5'b00001, 5'b00000, 5'b00100, 5'b00101, 5'b00110, 5'b01000,
             5'b01001, 5'b01100, 5'b01101, 5'b01110, 5'b00010, 5'b01000};
    t_a  = '{32'd5, 32'hFFFFFFFF, 32'hF0F0F0F0, 32'hF0F0F0F0, 32'hFFFF0000, 32'hFFFFFFFF,
             32'hFFFFFFFF, 32'h1, 32'h80000000, 32'h80000000, 32'h1234, 32'h1};
    t_b  = '{32'd7, 32'h2, 32'hFF00FF00, 32'h0F0F0000, 32'h0F0F0F0F, 32'h1,
             32'h1, 32'h21, 32'h4, 32'h24, 32'h5678, 32'hFFFFFFFF};
    t_r  = '{32'hFFFFFFFE, 32'h1, 32'hF000F000, 32'hFFFFF0F0, 32'hF0F00F0F, 32'h1,
             32'h0, 32'h2, 32'h08000000, 32'hF8000000, 32'h0, 32'h0};
    for (int i = 0; i < 12; i++) begin
      issue(t_op[i], t_a[i], t_b[i]);
      wait_done(lat, bc);
      n_cmp++; if (result !== t_r[i]) begin n_fail++; $display("FAIL single_%0d_result: got %h want %h", i, result, t_r[i]); end
      n_cmp++; if (lat !== 1) begin n_fail++; $display("FAIL single_%0d_latency: got %0d want 1", i, lat); end
      consume();
    end
  endtask

  task automatic test_muldiv();
    logic [4:0]  t_op [15];
    logic [31:0] t_a [15];
    logic [31:0] t_b [15];
    logic [31:0] t_r [15];
    logic        t_multi [15];
    int lat, bc, exp_lat, exp_bc;
    logic [31:0] exp_r;
    t_op = '{5'b10001, 5'b10000, 5'b10011, 5'b10010, 5'b10100, 5'b10110, 5'b10101, 5'b10111,
             5'b11001, 5'b10100, 5'b10110, 5'b10111, 5'b10100, 5'b10101, 5'b10110};
    t_a  = '{32'h80000000, 32'h12345678, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFF9, 32'hFFFFFFF9,
             32'd100, 32'd100, 32'd7, 32'h80000000, 32'h80000000, 32'h1234, 32'd5, 32'd5, 32'hFFFFFFF9};
    t_b  = '{32'h80000000, 32'h10, 32'hFFFFFFFF, 32'h2, 32'h2, 32'h2, 32'd7, 32'd7,
             32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h0, 32'h0, 32'h0, 32'h0};
    t_r  = '{32'h40000000, 32'h23456780, 32'hFFFFFFFE, 32'hFFFFFFFF, 32'hFFFFFFFD, 32'hFFFFFFFF,
             32'd14, 32'd2, 32'hFFFFFFFF, 32'h80000000, 32'h0, 32'h1234, 32'hFFFFFFFF, 32'hFFFFFFFF,
             32'hFFFFFFF9};
    t_multi = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1,
                1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    for (int i = 0; i < 15; i++) begin
      exp_r   = MD ? t_r[i] : 32'h0;
      exp_lat = (MD && t_multi[i]) ? 33 : 1;
      exp_bc  = (MD && t_multi[i]) ? 32 : 0;
      issue(t_op[i], t_a[i], t_b[i]);
      wait_done(lat, bc);
      n_cmp++; if (result !== exp_r) begin n_fail++; $display("FAIL muldiv_%0d_result: got %h want %h", i, result, exp_r); end
      n_cmp++; if (lat !== exp_lat) begin n_fail++; $display("FAIL muldiv_%0d_latency: got %0d want %0d", i, lat, exp_lat); end
      n_cmp++; if (bc !== exp_bc) begin n_fail++; $display("FAIL muldiv_%0d_busy_cycles: got %0d want %0d", i, bc, exp_bc); end
      consume();
    end
  endtask

  task automatic test_flush();
    int lat, bc;
    bit seen;
`ifdef SEQ_ALU_MULDIV_EN
    issue(5'b10101, 32'd100, 32'd7);
    repeat (8) tick();
    flush = 1'b1;
    tick();
    flush = 1'b0;
    n_cmp++; if ({out_valid, in_ready, busy} !== 3'b010) begin n_fail++; $display("FAIL flush_div_state: got ov/ir/busy=%b want 010", {out_valid, in_ready, busy}); end
    seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (out_valid) seen = 1'b1;
      tick();
    end
    n_cmp++; if (seen !== 1'b0) begin n_fail++; $display("FAIL flush_div_no_valid: got %b want 0", seen); end
`endif
    issue(5'b00000, 32'd2, 32'd3);
    wait_done(lat, bc);
    n_cmp++; if (result !== 32'd5) begin n_fail++; $display("FAIL flush_next_add: got %h want 5", result); end
    flush = 1'b1;
    tick();
    flush = 1'b0;
    n_cmp++; if ({out_valid, in_ready} !== 2'b01) begin n_fail++; $display("FAIL flush_done: got ov/ir=%b want 01", {out_valid, in_ready}); end
    op = 5'b00000; a = 32'd1; b = 32'd1; in_valid = 1'b1; flush = 1'b1;
    tick();
    in_valid = 1'b0; flush = 1'b0;
    n_cmp++; if ({out_valid, in_ready} !== 2'b01) begin n_fail++; $display("FAIL flush_override: got ov/ir=%b want 01", {out_valid, in_ready}); end
  endtask

  task automatic test_hold();
    issue(5'b00110, 32'h0000F0F0, 32'h00000FF0);
    op = 5'b00000; a = 32'd1; b = 32'd1; in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      n_cmp++;
      if ({out_valid, in_ready, result} !== {1'b1, 1'b0, 32'h0000FF00}) begin
        n_fail++; $display("FAIL hold_%0d: got ov/ir/res=%b/%b/%h want 1/0/0000ff00", i, out_valid, in_ready, result);
      end
      tick();
    end
    in_valid = 1'b0;
    consume();
    n_cmp++; if ({out_valid, in_ready} !== 2'b01) begin n_fail++; $display("FAIL hold_release: got ov/ir=%b want 01", {out_valid, in_ready}); end
  endtask

  task automatic test_back_to_back();
    int nv;
    nv = 0;
    op = 5'b00000; a = 32'd10; b = 32'd20; in_valid = 1'b1; out_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (out_valid) begin
        nv++;
        n_cmp++; if (result !== 32'd30) begin n_fail++; $display("FAIL b2b_result_%0d: got %h want 1e", i, result); end
      end
    end
    in_valid = 1'b0; out_ready = 1'b0;
    tick();
    n_cmp++; if (nv !== 5) begin n_fail++; $display("FAIL b2b_count: got %0d want 5", nv); end
  endtask

  task automatic test_reset_mid();
    bit seen;
    issue(5'b10000, 32'd3, 32'd5);
    repeat (5) tick();
    rst_n = 1'b0;
    #1;
    n_cmp++; if ({busy, out_valid, in_ready, result} !== {3'b001, 32'h0}) begin
      n_fail++; $display("FAIL reset_mid: got busy/ov/ir/res=%b/%b/%b/%h want 0/0/1/0", busy, out_valid, in_ready, result);
    end
    tick();
    rst_n = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (out_valid) seen = 1'b1;
    end
    n_cmp++; if (seen !== 1'b0) begin n_fail++; $display("FAIL reset_mid_no_valid: got %b want 0", seen); end
  endtask

  task automatic test_xlen8();
    logic [4:0] t_op [4];
    logic [7:0] t_a [4];
    logic [7:0] t_b [4];
    logic [7:0] t_r [4];
    t_op = '{5'b01110, 5'b00001, 5'b00000, 5'b01100};
    t_a  = '{8'h90, 8'h05, 8'hFF, 8'h01};
    t_b  = '{8'hFB, 8'h07, 8'h02, 8'h0A};
    t_r  = '{8'hF2, 8'hFE, 8'h01, 8'h04};
    for (int i = 0; i < 4; i++) begin
      e_op = t_op[i]; e_a = t_a[i]; e_b = t_b[i]; e_in_valid = 1'b1;
      tick();
      e_in_valid = 1'b0;
      n_cmp++; if ({e_out_valid, e_result} !== {1'b1, t_r[i]}) begin
        n_fail++; $display("FAIL x8_%0d: got ov/res=%b/%h want 1/%h", i, e_out_valid, e_result, t_r[i]);
      end
      e_out_ready = 1'b1;
      tick();
      e_out_ready = 1'b0;
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_muldiv();
    test_flush();
    test_hold();
    test_back_to_back();
    test_xlen8();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/seq_alu.md
SEQ_ALU -- requirements
Module: seq_alu

Interface
REQ-001 SHALL have parameter XLEN, default 32, operand/result width; legal values 8, 16, 32, 64.
REQ-002 SHALL have parameter SHW, default $clog2(XLEN), shift-amount width.
REQ-003 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-004 SHALL have port rst_n  input  1  reset; asynchronous, active-low.
REQ-005 SHALL have port in_valid  input  1  operation request.
REQ-006 SHALL have port in_ready  output  1  block can accept a request.
REQ-007 SHALL have port op  input  5  operation code.
REQ-008 SHALL have port a  input  XLEN  operand 1.
REQ-009 SHALL have port b  input  XLEN  operand 2.
REQ-010 SHALL have port flush  input  1  abort the current operation.
REQ-011 SHALL have port out_valid  output  1  result available.
REQ-012 SHALL have port out_ready  input  1  consumer takes the result.
REQ-013 SHALL have port result  output  XLEN  operation result.
REQ-014 SHALL have port busy  output  1  high in MUL or DIV state.

Function
REQ-015 SHALL accept a request on a rising edge where in_valid && in_ready, latching op, a and b.
REQ-016 SHALL decode op[4]=0 as: 0000 add, 0001 sub, 0100 and, 0101 or, 0110 xor, 1000 slt, 1001 sltu, 1100 sll, 1101 srl, 1110 sra; all other codes give result 0.
REQ-017 SHALL decode op[4]=1 by op[2:0] as: 000 mul, 001 mulh, 010 mulhsu, 011 mulhu, 100 div, 101 divu, 110 rem, 111 remu, with RV32M semantics generalised to XLEN; op[3] is ignored.
REQ-018 SHALL use only b[SHW-1:0] as the shift amount, with add/sub wrapping modulo 2^XLEN.
REQ-019 SHALL implement states IDLE, MUL, DIV and DONE.
REQ-020 SHALL go from IDLE to DONE on accepting a single-cycle op, so out_valid rises one cycle after acceptance.
REQ-021 SHALL go from IDLE to MUL or DIV on accepting a multi-cycle op: MUL is iterative shift-add, DIV is restoring, one bit per cycle, XLEN cycles, then DONE, so out_valid rises XLEN+1 cycles after acceptance.
REQ-022 SHALL hold result and out_valid stable in DONE until out_ready is high, then go to IDLE.
REQ-023 SHALL drive in_ready high only in IDLE, so back-to-back acceptance occurs at best every 2 cycles.
REQ-024 SHALL treat divide-by-zero as a 1-cycle op: div/divu give all-ones, rem/remu give a.
REQ-025 SHALL treat signed overflow (a = most-negative, b = -1) as a 1-cycle op: div gives a, rem gives 0.
REQ-026 SHALL, on flush high in any state, go to IDLE on the next edge with out_valid low and discard the result; flush overrides a simultaneous in_valid acceptance.
REQ-027 SHALL ignore in_valid and operand changes while busy.
REQ-028 SHALL present result from a register, with no combinational path from a, b or op to result.

Reset
REQ-029 SHALL, with rst_n low, force state to IDLE, result to 0, out_valid to 0 and busy to 0, and clear the internal iteration counter and accumulators.
REQ-030 SHALL, on reset during MUL or DIV, abandon the operation and produce no out_valid after release.
REQ-031 SHALL drive in_ready high in the first cycle after rst_n deasserts.

Configuration
REQ-032 SHALL compile in the mul/div engine only when SEQ_ALU_MULDIV_EN is defined.
REQ-033 SHALL, when SEQ_ALU_MULDIV_EN is undefined, treat op[4]=1 as a single-cycle op with result 0, never enter MUL or DIV, and hold busy at 0.

Verification
REQ-034 SHALL check XLEN=32 with op=00001, a=5, b=7, giving result 0xFFFFFFFE with out_valid one cycle after accept.
REQ-035 SHALL check XLEN=32 with op=10001 (mulh), a=0x80000000, b=0x80000000, giving result 0x40000000 with out_valid 33 cycles after accept and busy high for 32 cycles.
REQ-036 SHALL check op=10100 (div), a=0x80000000, b=0xFFFFFFFF, giving result 0x80000000 after 1 cycle; op=10111 (remu) with b=0 giving result equal to a after 1 cycle.
REQ-037 SHALL check a divu started with flush asserted in cycle 10, giving out_valid never rising, in_ready high the next cycle, and the next add correct.
REQ-038 SHALL check out_ready held low for 5 cycles in DONE, giving result and out_valid stable and in_ready low; one cycle after out_ready rises, in_ready is high.
REQ-039 SHALL check XLEN=8 with op=01110 (sra), a=0x90, b=0xFB (amount 3), giving result 0xF2.
